hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32 core; sits in ID, directly upstream of the main decoder.
- Produces the decoder's NoOp input (bubble insertion), PC/IF-ID write enables, IF/ID flush and a global freeze for data-cache misses.
- Holds a small FSM that tracks a memory stall, a miss-length watchdog and optional performance counters.

Parameters:
- TIMEOUT, 64, cycles a memory stall may last before timeout_o sets (1..2^16-1).
- CNT_W, 32, width of each performance counter.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-high reset
- id_opcode_i  in  7  opcode of the instruction in ID
- id_rs1_i  in  5  rs1 field in ID
- id_rs2_i  in  5  rs2 field in ID
- ex_memread_i  in  1  MemRead of the instruction in EX
- ex_rd_i  in  5  rd of the instruction in EX
- branch_taken_i  in  1  beq resolved taken in ID
- mem_stall_i  in  1  data cache busy (miss in progress), combinational from the cache
- noop_o  out  1  to the decoder NoOp input; zeroes all control for the ID/EX stage
- pc_write_o  out  1  PC register write enable
- ifid_write_o  out  1  IF/ID register write enable
- ifid_flush_o  out  1  IF/ID flush (inserts nop)
- pipe_stall_o  out  1  freezes ID/EX, EX/MEM and MEM/WB
- timeout_o  out  1  sticky: a memory stall exceeded TIMEOUT
- stall_cnt_o  out  CNT_W  cycles spent frozen by mem_stall_i
- bubble_cnt_o  out  CNT_W  load-use bubbles inserted
- flush_cnt_o  out  CNT_W  IF/ID flushes issued

Behaviour:
- Source usage:
  - uses_rs1 for opcodes 0010011, 0110011, 0000011, 0100011, 1100011.
  - uses_rs2 for 0110011, 0100011, 1100011.
  - Any other opcode uses neither register.
- Load-use condition: load_use = ex_memread_i & (ex_rd_i != 0) & ((uses_rs1 & id_rs1_i == ex_rd_i) | (uses_rs2 & id_rs2_i == ex_rd_i)). Register x0 never creates a hazard.
- Control outputs are combinational (Mealy) from the current state and inputs, so they act in the same cycle. Priority: reset > mem_stall > load_use > branch_taken.
  - mem_stall_i=1: pipe_stall_o=1, pc_write_o=0, ifid_write_o=0, noop_o=0, ifid_flush_o=0.
  - load_use (no mem stall): noop_o=1, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, pipe_stall_o=0.
  - branch_taken_i (no mem stall, no load_use): ifid_flush_o=1, pc_write_o=1, ifid_write_o=1.
  - Otherwise: pc_write_o=1, ifid_write_o=1, all others 0.
- FSM states:
  - RUN: go to MEM_WAIT when mem_stall_i=1.
  - MEM_WAIT: return to RUN on the first cycle mem_stall_i=0. Outputs in that cycle follow the load_use and branch rules, so a load-use hazard still pending after a miss gets its bubble then.
- Watchdog:
  - wait_cnt (16 bit) clears on entry to MEM_WAIT and increments each cycle mem_stall_i=1; it saturates.
  - When wait_cnt reaches TIMEOUT, timeout_o sets and stays set until reset. The stall itself is never aborted.
- Counters (saturating at all-ones, never wrap):
  - stall_cnt_o increments once per cycle with mem_stall_i=1.
  - bubble_cnt_o increments once per cycle with noop_o=1 due to load_use.
  - flush_cnt_o increments once per cycle with ifid_flush_o=1.
- Simultaneous events:
  - load_use with branch_taken_i: stall only, no flush. The branch re-resolves the next cycle.
  - mem_stall with anything else: freeze only; no counter other than stall_cnt_o advances.
- Reset:
  - While rst_i=1: state=RUN, wait_cnt=0, timeout_o=0, all counters 0.
  - Also while rst_i=1: noop_o=1, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, pipe_stall_o=0.
  - Reset asserted mid-MEM_WAIT aborts the wait immediately (asynchronous).

Optional Feature:
- HAZARD_PERF_CNT_EN defined: stall_cnt_o, bubble_cnt_o and flush_cnt_o are implemented as above.
- Not defined: no counter flops; those three outputs are tied to 0. Ports remain; watchdog and FSM are unaffected.

Decomposition:
- Shared package (core_pkg) holds:
  - opcode constants: OP_IMM=0010011, OP_REG=0110011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011.
  - FSM state typedef (RUN, MEM_WAIT).
  - the register-index width constant (5).
- One sub-module: sat_counter (parameter W; ports clk_i, rst_i, inc_i, cnt_o), instantiated three times under HAZARD_PERF_CNT_EN.

Test Plan:
- lw x5 in EX (ex_memread_i=1, ex_rd_i=5); add x6,x5,x7 in ID -> noop_o=1, pc_write_o=0, ifid_write_o=0 for 1 cycle; bubble_cnt_o=1.
- ex_rd_i=0 with ex_memread_i=1, id_rs1_i=0 -> no stall. Separately, a jal opcode in ID with rs1 field matching ex_rd_i -> no stall.
- mem_stall_i high 10 cycles -> pipe_stall_o=1 and pc_write_o=0 in exactly those 10 cycles; stall_cnt_o=10; state back to RUN on cycle 11.
- TIMEOUT=4, mem_stall_i high 6 cycles -> timeout_o rises when wait_cnt reaches 4 and stays 1 after the stall ends, until rst_i.
- branch_taken_i=1 with load_use=1 -> ifid_flush_o=0 and noop_o=1; next cycle (load_use=0) -> ifid_flush_o=1; flush_cnt_o=1.
- rst_i pulsed during MEM_WAIT -> state RUN, counters 0, timeout_o=0 asynchronously; noop_o=1 while rst_i is high.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared opcode constants, register index width and hazard FSM states
package core_pkg;
    localparam int REG_W = 5;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    typedef enum logic {RUN, MEM_WAIT} state_t;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    // count qualified events, hold once saturated
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt_o <= '0;
        else if (inc_i && !(&cnt_o)) cnt_o <= cnt_o + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage load-use/branch/mem-stall control with watchdog; HAZARD_PERF_CNT_EN adds perf counters
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       id_opcode_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             branch_taken_i,
    input  logic             mem_stall_i,
    output logic             noop_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             pipe_stall_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_nxt;
    logic        uses_rs1, uses_rs2, load_use;

    // decode which source registers the ID instruction actually reads
    always_comb begin
        uses_rs1 = id_opcode_i inside {OP_IMM, OP_REG, OP_LOAD, OP_STORE, OP_BRANCH};
        uses_rs2 = id_opcode_i inside {OP_REG, OP_STORE, OP_BRANCH};
    end

    assign load_use = ex_memread_i && (ex_rd_i != '0) &&
                      ((uses_rs1 && id_rs1_i == ex_rd_i) || (uses_rs2 && id_rs2_i == ex_rd_i));

    // next state and Mealy control: reset > mem stall > load-use > taken branch
    always_comb begin
        state_nxt    = mem_stall_i ? MEM_WAIT : RUN;
        noop_o       = 1'b0;
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        pipe_stall_o = 1'b0;
        if (rst_i) begin
            noop_o       = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (mem_stall_i) begin
            pipe_stall_o = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (load_use) begin
            noop_o       = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end
    end

    // first stall cycle restarts the miss length at 1, later ones saturate upward
    assign wait_nxt = !mem_stall_i   ? wait_cnt :
                      state == RUN   ? 16'd1 :
                      (&wait_cnt)    ? wait_cnt : wait_cnt + 16'd1;

    // state, watchdog length and sticky timeout flag
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state     <= RUN;
            wait_cnt  <= '0;
            timeout_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            timeout_o <= timeout_o || (wait_nxt >= 16'(TIMEOUT));
        end

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i), .rst_i (rst_i), .inc_i (mem_stall_i), .cnt_o (stall_cnt_o)
    );
    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk_i (clk_i), .rst_i (rst_i), .inc_i (load_use && !mem_stall_i), .cnt_o (bubble_cnt_o)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i), .rst_i (rst_i), .inc_i (ifid_flush_o), .cnt_o (flush_cnt_o)
    );
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
    assign flush_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl (TIMEOUT=4)
module tb_hazard_ctrl;
    localparam logic [6:0] IMM = 7'b0010011, REG = 7'b0110011, LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic noop, pcw, ifw, fl, ps, to;
        logic [31:0] sc, bc, fc;
    } exp_t;

    logic clk = 1'b0, rst_i = 1'b1;
    logic [6:0] id_opcode_i = IMM;
    logic [4:0] id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
    logic ex_memread_i = 1'b0, branch_taken_i = 1'b0, mem_stall_i = 1'b0;
    logic noop_o, pc_write_o, ifid_write_o, ifid_flush_o, pipe_stall_o, timeout_o;
    logic [31:0] stall_cnt_o, bubble_cnt_o, flush_cnt_o;

    exp_t q[$];
    int n_chk = 0, n_err = 0;
    bit m_wait_st = 1'b0, m_to = 1'b0;
    int m_wait = 0, m_sc = 0, m_bc = 0, m_fc = 0;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .id_opcode_i(id_opcode_i), .id_rs1_i(id_rs1_i),
        .id_rs2_i(id_rs2_i), .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
        .branch_taken_i(branch_taken_i), .mem_stall_i(mem_stall_i), .noop_o(noop_o),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
        .pipe_stall_o(pipe_stall_o), .timeout_o(timeout_o), .stall_cnt_o(stall_cnt_o),
        .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit hazard(input logic [6:0] op, input logic [4:0] s1, s2,
                                  input logic mr, input logic [4:0] rd);
        bit r1, r2;
        r1 = (op == IMM) || (op == REG) || (op == LD) || (op == ST) || (op == BR);
        r2 = (op == REG) || (op == ST) || (op == BR);
        return mr && rd != 0 && ((r1 && s1 == rd) || (r2 && s2 == rd));
    endfunction

    task automatic step(input logic r, input logic [6:0] op, input logic [4:0] s1, s2,
                        input logic mr, input logic [4:0] rd, input logic br, ms);
        exp_t e, g;
        bit lu;
        @(negedge clk);
        rst_i = r; id_opcode_i = op; id_rs1_i = s1; id_rs2_i = s2;
        ex_memread_i = mr; ex_rd_i = rd; branch_taken_i = br; mem_stall_i = ms;
        lu = hazard(op, s1, s2, mr, rd);
        e = '0;
        if (r) begin
            e.noop = 1'b1;
        end else begin
            e.ps   = ms;
            e.noop = !ms && lu;
            e.pcw  = !ms && !lu;
            e.ifw  = !ms && !lu;
            e.fl   = !ms && !lu && br;
            e.to   = m_to;
            e.sc   = PERF ? m_sc : 0;
            e.bc   = PERF ? m_bc : 0;
            e.fc   = PERF ? m_fc : 0;
        end
        q.push_back(e);
        #1;
        g = q.pop_front();
        chk("noop", noop_o, g.noop);
        chk("pc_write", pc_write_o, g.pcw);
        chk("ifid_write", ifid_write_o, g.ifw);
        chk("ifid_flush", ifid_flush_o, g.fl);
        chk("pipe_stall", pipe_stall_o, g.ps);
        chk("timeout", timeout_o, g.to);
        chk("stall_cnt", stall_cnt_o, g.sc);
        chk("bubble_cnt", bubble_cnt_o, g.bc);
        chk("flush_cnt", flush_cnt_o, g.fc);
        if (r) begin
            m_wait_st = 0; m_wait = 0; m_to = 0; m_sc = 0; m_bc = 0; m_fc = 0;
        end else if (ms) begin
            m_wait = m_wait_st ? (m_wait < 65535 ? m_wait + 1 : m_wait) : 1;
            m_wait_st = 1;
            m_sc++;
            if (m_wait >= 4) m_to = 1;
        end else begin
            m_wait_st = 0;
            if (lu) m_bc++;
            else if (br) m_fc++;
        end
    endtask

    task automatic idle();
        step(0, IMM, 5'd1, 5'd2, 0, 5'd0, 0, 0);
    endtask

    initial begin
        step(1, IMM, 0, 0, 0, 0, 0, 0);
        step(1, REG, 5, 7, 1, 5, 1, 1);
        idle();
        step(0, REG, 5, 7, 1, 5, 0, 0);
        idle();
        chk("bubble_after_lw", bubble_cnt_o, PERF ? 32'd1 : 32'd0);
        step(0, REG, 0, 0, 1, 0, 0, 0);
        step(0, JAL, 5, 5, 1, 5, 0, 0);
        step(0, ST, 3, 9, 1, 9, 0, 0);
        step(0, IMM, 3, 9, 1, 9, 0, 0);
        step(0, BR, 4, 9, 1, 9, 0, 0);
        step(0, BR, 5, 6, 1, 5, 1, 0);
        step(0, BR, 5, 6, 0, 5, 1, 0);
        idle();
        chk("flush_once", flush_cnt_o, PERF ? 32'd1 : 32'd0);
        for (int i = 0; i < 10; i++)
            step(0, i[0] ? REG : BR, 5, 5, i[1], 5, i[2], 1);
        idle();
        chk("stall_ten", stall_cnt_o, PERF ? 32'd10 : 32'd0);
        chk("timeout_sticky", timeout_o, 1'b1);
        step(0, REG, 5, 7, 1, 5, 1, 0);
        for (int i = 0; i < 3; i++) step(0, IMM, 0, 0, 0, 0, 0, 1);
        step(1, IMM, 0, 0, 0, 0, 0, 1);
        step(0, IMM, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, IMM, 0, 0, 0, 0, 0, 1);
        step(0, IMM, 0, 0, 0, 0, 1, 1);
        idle();
        chk("timeout_after_rearm", timeout_o, 1'b1);
        step(0, BR, 1, 2, 0, 0, 1, 0);
        idle();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
